bsg_scatter_gather_stream: RTL and testbench

//  Sequential successor to the combinational scatter/gather index generator. Accepts a
//  vec_size_p-bit valid mask and streams the indices of its set bits (gather/"bk" map),

---
 rtl/bsg_scatter_gather_stream.sv | 93 +++++++++
 tb/tb_bsg_scatter_gather_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_scatter_gather_stream.sv
// Streams ascending indices of set mask bits, lanes_p per beat, with each beat's starting rank.
// Mask accepted cycle N -> first beat N+1; outputs hold while yumi_i=0; one IDLE bubble between masks.
module bsg_scatter_gather_stream #(
  parameter int vec_size_p = 128,
  parameter int lanes_p    = 4,
  localparam int lg_vec_size_lp = $clog2(vec_size_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                v_i,
  input  logic [vec_size_p-1:0]               vec_i,
  output logic                                ready_o,
  output logic                                v_o,
  output logic [lanes_p*lg_vec_size_lp-1:0]   idx_o,
  output logic [lanes_p-1:0]                  idx_v_o,
  output logic [lg_vec_size_lp:0]             rank_o,
  output logic                                last_o,
  input  logic                                yumi_i
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                          state_q;
  logic [vec_size_p-1:0]           mask_q;
  logic [lg_vec_size_lp:0]         rank_q;

  logic [vec_size_p-1:0]           rem_d;
  logic [lanes_p*lg_vec_size_lp-1:0] idx_d;
  logic [lanes_p-1:0]              idx_v_d;
  logic [lg_vec_size_lp:0]         cnt_d;

  // Per lane: pick the lowest remaining set bit, then strip it with rem & (rem-1).
  always_comb begin
    rem_d   = mask_q;
    idx_d   = '0;
    idx_v_d = '0;
    cnt_d   = '0;
    for (int j = 0; j < lanes_p; j++) begin
      for (int i = vec_size_p-1; i >= 0; i--) begin
        if (rem_d[i]) idx_d[j*lg_vec_size_lp +: lg_vec_size_lp] = lg_vec_size_lp'(i);
      end
      if (|rem_d) begin
        idx_v_d[j] = 1'b1;
        cnt_d      = cnt_d + {{lg_vec_size_lp{1'b0}}, 1'b1};
        rem_d      = rem_d & (rem_d - {{(vec_size_p-1){1'b0}}, 1'b1});
      end
    end
  end

  assign ready_o = reset_n_i && (state_q == IDLE);
  assign v_o     = (state_q == EMIT);
  assign idx_o   = idx_d;
  assign idx_v_o = idx_v_d;
  assign rank_o  = rank_q;
  assign last_o  = (state_q == EMIT) && (rem_d == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rank_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (v_i) begin
            mask_q  <= vec_i;
            rank_q  <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (yumi_i) begin
            if (rem_d == '0) begin
              mask_q  <= '0;
              rank_q  <= '0;
              state_q <= IDLE;
            end else begin
              mask_q  <= rem_d;
              rank_q  <= rank_q + cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Consumer must only take a beat that is being offered.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(yumi_i && !v_o));
  end

endmodule

// File: tb/tb_bsg_scatter_gather_stream.sv
// Directed + randomized bench for bsg_scatter_gather_stream (128-bit mask, 4 lanes).
module tb_bsg_scatter_gather_stream;
  localparam int VS = 128;
  localparam int LN = 4;
  localparam int LG = 7;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              v_i;
  logic [VS-1:0]     vec_i;
  logic              ready_o;
  logic              v_o;
  logic [LN*LG-1:0]  idx_o;
  logic [LN-1:0]     idx_v_o;
  logic [LG:0]       rank_o;
  logic              last_o;
  logic              yumi_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  bsg_scatter_gather_stream #(.vec_size_p(VS), .lanes_p(LN)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .vec_i(vec_i), .ready_o(ready_o),
    .v_o(v_o), .idx_o(idx_o), .idx_v_o(idx_v_o), .rank_o(rank_o), .last_o(last_o),
    .yumi_i(yumi_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions, chopped into groups of LN.
  task automatic expect_beat(input logic [VS-1:0] m, input int k, input string tag);
    int q[$];
    logic [LN*LG-1:0] e_idx;
    logic [LN-1:0]    e_v;
    int               n;
    for (int i = 0; i < VS; i++) if (m[i]) q.push_back(i);
    n     = q.size();
    e_idx = '0;
    e_v   = '0;
    for (int j = 0; j < LN; j++) begin
      if (k*LN + j < n) begin
        e_idx[j*LG +: LG] = LG'(q[k*LN + j]);
        e_v[j] = 1'b1;
      end
    end
    chk({tag, ".v_o"},   64'(v_o), 64'(1));
    chk({tag, ".idx"},   64'(idx_o), 64'(e_idx));
    chk({tag, ".idx_v"}, 64'(idx_v_o), 64'(e_v));
    chk({tag, ".rank"},  64'(rank_o), 64'(k*LN));
    chk({tag, ".last"},  64'(last_o), 64'((n - k*LN) <= LN));
    chk({tag, ".ready"}, 64'(ready_o), 64'(0));
  endtask

  function automatic int num_beats(input logic [VS-1:0] m);
    int n = 0;
    for (int i = 0; i < VS; i++) n += int'(m[i]);
    return (n == 0) ? 1 : (n + LN - 1) / LN;
  endfunction

  // Waits (bounded) for ready_o, presents mask for one cycle; returns at the first-beat negedge.
  task automatic send(input logic [VS-1:0] m, input string tag);
    int guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    tests++;
    if (guard >= 100) begin
      fails++;
      $error("FAIL %s.ready_timeout: got 0 expected 1", tag);
    end
    v_i   = 1'b1;
    vec_i = m;
    @(negedge clk_i);
    v_i   = 1'b0;
    vec_i = $urandom;
  endtask

  // Consumes every beat of m (optionally with random stalls), then checks the bubble cycle.
  task automatic drain(input logic [VS-1:0] m, input int first_k, input bit stalls, input string tag);
    int nb = num_beats(m);
    for (int k = first_k; k < nb; k++) begin
      expect_beat(m, k, tag);
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          yumi_i = 1'b0;
          @(negedge clk_i);
          expect_beat(m, k, {tag, ".stall"});
        end
      end
      yumi_i = 1'b1;
      @(negedge clk_i);
      yumi_i = 1'b0;
    end
    chk({tag, ".bubble_v"},     64'(v_o), 64'(0));
    chk({tag, ".bubble_ready"}, 64'(ready_o), 64'(1));
  endtask

  logic [VS-1:0] m;
  logic [VS-1:0] hold_idx;

  initial begin
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    vec_i     = '0;
    yumi_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst.ready", 64'(ready_o), 64'(0));
    chk("rst.v_o",   64'(v_o), 64'(0));
    chk("rst.idx",   64'(idx_o), 64'(0));
    chk("rst.idx_v", 64'(idx_v_o), 64'(0));
    chk("rst.rank",  64'(rank_o), 64'(0));
    reset_n_i = 1'b1;
    #1;
    chk("rst.ready_release", 64'(ready_o), 64'(1));

    // 1: empty mask
    send('0, "empty");
    drain('0, 0, 1'b0, "empty");

    // 2: sparse mask
    m = '0; m[0] = 1'b1; m[5] = 1'b1; m[6] = 1'b1; m[64] = 1'b1; m[127] = 1'b1;
    send(m, "sparse");
    drain(m, 0, 1'b0, "sparse");

    // 3: full mask, 32 beats
    send('1, "full");
    drain('1, 0, 1'b0, "full");

    // 4: stalled consumer, v_i toggling must be ignored
    m = '0; m[3] = 1'b1; m[9] = 1'b1;
    send(m, "hold");
    hold_idx = '0;
    hold_idx[LG-1:0] = LG'(3);
    hold_idx[2*LG-1:LG] = LG'(9);
    for (int c = 0; c < 10; c++) begin
      v_i   = ~v_i;
      vec_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_i);
      chk("hold.v_o",   64'(v_o), 64'(1));
      chk("hold.idx",   64'(idx_o), hold_idx[63:0]);
      chk("hold.rank",  64'(rank_o), 64'(0));
      chk("hold.ready", 64'(ready_o), 64'(0));
    end
    v_i = 1'b0;
    drain(m, 0, 1'b0, "hold");

    // 5: reset mid-stream
    send('1, "rstmid");
    expect_beat('1, 0, "rstmid");
    yumi_i = 1'b1;
    @(negedge clk_i);
    expect_beat('1, 1, "rstmid");
    @(negedge clk_i);
    yumi_i    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("rstmid.ready_in_reset", 64'(ready_o), 64'(0));
    @(negedge clk_i);
    chk("rstmid.v_o_after", 64'(v_o), 64'(0));
    chk("rstmid.ready_held", 64'(ready_o), 64'(0));
    reset_n_i = 1'b1;
    #1;
    chk("rstmid.ready_release", 64'(ready_o), 64'(1));
    m = '0; m[7] = 1'b1;
    send(m, "post_rst");
    drain(m, 0, 1'b0, "post_rst");

    // 6: v_i held high across two masks
    @(negedge clk_i);
    v_i = 1'b1;
    vec_i = '0; vec_i[1] = 1'b1;
    @(negedge clk_i);
    m = '0; m[1] = 1'b1;
    expect_beat(m, 0, "b2b.A");
    vec_i = '0; vec_i[2] = 1'b1; vec_i[3] = 1'b1;
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    chk("b2b.bubble_v",     64'(v_o), 64'(0));
    chk("b2b.bubble_ready", 64'(ready_o), 64'(1));
    @(negedge clk_i);
    v_i = 1'b0;
    m = '0; m[2] = 1'b1; m[3] = 1'b1;
    drain(m, 0, 1'b0, "b2b.B");

    // Random masks of varying density with random consumer stalls
    for (int r = 0; r < 30; r++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      case (r % 3)
        0: m = m & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
        1: m = m & {4{32'h0000_0001 << $urandom_range(0, 31)}};
        default: ;
      endcase
      send(m, "rand");
      drain(m, 0, 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
